// File: rtl/cc_pkg.sv
// Shared definitions for the cross-correlation sample streamer.
//   CC_* constants : default frame geometry, lag-to-tau scaling and wait budget
//   CC_S, CC_FS    : scaling numerator (2^25) and sample rate behind CC_TAU_MUL
//   cc_state_t     : streamer FSM encoding
//   cc_beat_t      : one capture beat, four 16-bit mic samples, [0] = mic 0
//   cc_scale_lag   : signed lag * mul / 2^shift, truncated toward zero
package cc_pkg;

  localparam int unsigned CC_LENGTH    = 8192;
  localparam int unsigned CC_ADDR_W    = 13;
  localparam int unsigned CC_TAU_MUL   = 44739;
  localparam int unsigned CC_TAU_SHIFT = 16;
  localparam int unsigned CC_TIMEOUT   = 65536;
  localparam int unsigned CC_S         = 33554432;
  localparam int unsigned CC_FS        = 49152000;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_START,
    ST_STREAM,
    ST_WAIT,
    ST_SCALE,
    ST_OUT
  } cc_state_t;

  typedef logic [3:0][15:0] cc_beat_t;

  // Negative products get a bias of 2^shift-1 before the arithmetic shift so
  // the quotient rounds toward zero instead of toward minus infinity.
  function automatic logic signed [31:0] cc_scale_lag(input logic signed [15:0] lag,
                                                      input int unsigned mul,
                                                      input int unsigned shift);
    logic signed [32:0] prod;
    logic signed [32:0] bias;
    logic signed [32:0] quo;
    prod = 33'(lag) * $signed(33'(mul));
    bias = prod[32] ? $signed(33'((64'd1 << shift) - 64'd1)) : '0;
    quo  = (prod + bias) >>> shift;
    return quo[31:0];
  endfunction

endpackage

// File: rtl/cc_frame_ram.sv
// Frame memory: DEPTH beats of four 16-bit samples.
//   clk     : single clock
//   wr_en   : write wr_data to wr_addr on the rising edge
//   rd_addr : read address, sampled on the rising edge
//   rd_data : registered read data (one-cycle read latency)
// Contents are not reset.
module cc_frame_ram
  import cc_pkg::*;
#(
  parameter int unsigned DEPTH  = CC_LENGTH,
  parameter int unsigned ADDR_W = CC_ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  cc_beat_t          wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output cc_beat_t          rd_data
);

  cc_beat_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/cc_sample_streamer.sv
// Captures one frame of four-mic samples, streams it to three correlators,
// waits for their lags and converts them to scaled delays.
//   clk, rst               : clock, synchronous active-high reset
//   in_valid/in_ready      : capture handshake, in_ready only while filling
//   in_s0..in_s3           : the four mic samples of one capture beat
//   start                  : one-cycle correlation start, aligned with sample 0
//   m0..m3                 : registered streamed samples (m0 = reference), 0 when idle
//   cc_done, cc_index1..3  : correlator done and signed lags
//   tau1..3, tau_valid     : scaled delays and their one-cycle strobe
//   busy                   : high whenever not filling
//   timeout_err            : set when cc_done never came, cleared by start
module cc_sample_streamer
  import cc_pkg::*;
#(
  parameter int unsigned LENGTH    = CC_LENGTH,
  parameter int unsigned ADDR_W    = CC_ADDR_W,
  parameter int unsigned TAU_MUL   = CC_TAU_MUL,
  parameter int unsigned TAU_SHIFT = CC_TAU_SHIFT,
  parameter int unsigned TIMEOUT   = CC_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        in_s0,
  input  logic [15:0]        in_s1,
  input  logic [15:0]        in_s2,
  input  logic [15:0]        in_s3,
  output logic               start,
  output logic [15:0]        m0,
  output logic [15:0]        m1,
  output logic [15:0]        m2,
  output logic [15:0]        m3,
  input  logic               cc_done,
  input  logic [15:0]        cc_index1,
  input  logic [15:0]        cc_index2,
  input  logic [15:0]        cc_index3,
  output logic signed [31:0] tau1,
  output logic signed [31:0] tau2,
  output logic signed [31:0] tau3,
  output logic               tau_valid,
  output logic               busy,
  output logic               timeout_err
);

  cc_state_t         state_q, state_d;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [ADDR_W-1:0] sample_idx;
  logic [31:0]       wait_cnt;
  logic              fill_last;
  logic              stream_last;
  logic              wait_last;
  logic              ram_we;
  logic              show_next;
  cc_beat_t          ram_q;
  cc_beat_t          m_q;
  logic signed [15:0] lag1, lag2, lag3;

  assign ram_we      = (state_q == ST_FILL) && in_valid;
  assign fill_last   = ram_we && (wr_addr == ADDR_W'(LENGTH - 1));
  assign stream_last = (state_q == ST_STREAM) && (sample_idx == ADDR_W'(LENGTH - 1));
  assign wait_last   = (wait_cnt == 32'(TIMEOUT - 1));
  assign show_next   = (state_d == ST_START) || (state_d == ST_STREAM);

  // Two-stage read path (RAM register, then m register): sample k must be
  // addressed two cycles before it is shown. While filling the address rests
  // at 0; on the final write cycle it steps to 1 so sample 1 is in flight when
  // START shows sample 0, and rd_addr then runs two ahead of sample_idx.
  assign ram_rd_addr = rd_addr + ADDR_W'(fill_last);

  cc_frame_ram #(
    .DEPTH (LENGTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (ram_we),
    .wr_addr(wr_addr),
    .wr_data({in_s3, in_s2, in_s1, in_s0}),
    .rd_addr(ram_rd_addr),
    .rd_data(ram_q)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FILL;
    else     state_q <= state_d;
  end

  // Next-state logic; cc_done is only looked at in WAIT
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FILL:   if (fill_last) state_d = ST_START;
      ST_START:  state_d = ST_STREAM;
      ST_STREAM: if (stream_last) state_d = ST_WAIT;
      ST_WAIT: begin
        if (cc_done)        state_d = ST_SCALE;
        else if (wait_last) state_d = ST_FILL;
      end
      ST_SCALE:  state_d = ST_OUT;
      ST_OUT:    state_d = ST_FILL;
      default:   state_d = ST_FILL;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready  = (state_q == ST_FILL);
    busy      = (state_q != ST_FILL);
    start     = (state_q == ST_START);
    tau_valid = (state_q == ST_OUT);
  end

  // Datapath: addresses, counters, stream register, lag latch, scaler
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr     <= '0;
      rd_addr     <= '0;
      sample_idx  <= '0;
      wait_cnt    <= '0;
      m_q         <= '0;
      lag1        <= '0;
      lag2        <= '0;
      lag3        <= '0;
      tau1        <= '0;
      tau2        <= '0;
      tau3        <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (ram_we) wr_addr <= fill_last ? '0 : wr_addr + 1'b1;

      unique case (state_q)
        ST_FILL:             rd_addr <= fill_last ? ADDR_W'(2) : '0;
        ST_START, ST_STREAM: rd_addr <= rd_addr + 1'b1;
        default:             rd_addr <= '0;
      endcase

      if (fill_last)                                        sample_idx <= '0;
      else if (state_q == ST_START || state_q == ST_STREAM) sample_idx <= sample_idx + 1'b1;

      wait_cnt <= (state_q == ST_WAIT) ? wait_cnt + 32'd1 : '0;

      m_q <= show_next ? ram_q : '0;

      if (state_q == ST_START) timeout_err <= 1'b0;
      else if (state_q == ST_WAIT && !cc_done && wait_last) timeout_err <= 1'b1;

      if (state_q == ST_WAIT && cc_done) begin
        lag1 <= cc_index1;
        lag2 <= cc_index2;
        lag3 <= cc_index3;
      end

      if (state_q == ST_SCALE) begin
        tau1 <= cc_scale_lag(lag1, TAU_MUL, TAU_SHIFT);
        tau2 <= cc_scale_lag(lag2, TAU_MUL, TAU_SHIFT);
        tau3 <= cc_scale_lag(lag3, TAU_MUL, TAU_SHIFT);
      end
    end
  end

  assign m0 = m_q[0];
  assign m1 = m_q[1];
  assign m2 = m_q[2];
  assign m3 = m_q[3];

endmodule

// File: tb/tb_cc_sample_streamer.sv
module tb_cc_sample_streamer;

  localparam int unsigned L  = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned TO = 100;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [15:0]        in_s0, in_s1, in_s2, in_s3;
  logic               start;
  logic [15:0]        m0, m1, m2, m3;
  logic               cc_done;
  logic [15:0]        cc_index1, cc_index2, cc_index3;
  logic signed [31:0] tau1, tau2, tau3;
  logic               tau_valid;
  logic               busy;
  logic               timeout_err;

  int n_total = 0;
  int n_bad   = 0;
  logic [63:0] exp_beat [L];
  logic        terr_at_1;

  cc_sample_streamer #(
    .LENGTH   (L),
    .ADDR_W   (AW),
    .TAU_MUL  (44739),
    .TAU_SHIFT(16),
    .TIMEOUT  (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_s0      (in_s0),
    .in_s1      (in_s1),
    .in_s2      (in_s2),
    .in_s3      (in_s3),
    .start      (start),
    .m0         (m0),
    .m1         (m1),
    .m2         (m2),
    .m3         (m3),
    .cc_done    (cc_done),
    .cc_index1  (cc_index1),
    .cc_index2  (cc_index2),
    .cc_index3  (cc_index3),
    .tau1       (tau1),
    .tau2       (tau2),
    .tau3       (tau3),
    .tau_valid  (tau_valid),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fill one frame with a ramp starting at base; toggle inserts idle cycles
  // carrying junk data that must not be captured.
  task automatic fill_frame(input int base, input bit toggle);
    int acc = 0;
    int cyc = 0;
    chk("fill_ready", in_ready, 1);
    while (acc < int'(L)) begin
      if (!toggle || cyc % 2 == 0) begin
        in_valid = 1'b1;
        in_s0 = 16'(base + acc);
        in_s1 = 16'(base + acc + 1);
        in_s2 = 16'(base + acc + 2);
        in_s3 = 16'(base + acc + 3);
        exp_beat[acc] = {in_s3, in_s2, in_s1, in_s0};
        acc++;
      end else begin
        in_valid = 1'b0;
        in_s0 = 16'hBEEF; in_s1 = 16'hBEEF; in_s2 = 16'hBEEF; in_s3 = 16'hBEEF;
        chk("fill_ready_gap", in_ready, 1);
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  // Expect start with sample 0, then one sample per cycle; optionally poke
  // in_valid with junk, or assert rst while sample abort_at is shown.
  task automatic stream_check(input int abort_at, input bit poke);
    int waited = 0;
    while (start !== 1'b1 && waited < 8) begin
      step();
      waited++;
    end
    chk("start_seen", start, 1);
    if (start === 1'b1) begin
      for (int k = 0; k < int'(L); k++) begin
        chk("m", {m3, m2, m1, m0}, exp_beat[k]);
        chk("start", start, (k == 0) ? 1 : 0);
        chk("ready_stream", in_ready, 0);
        if (k == 1) terr_at_1 = timeout_err;
        if (k == abort_at) begin
          in_valid = 1'b0;
          rst = 1'b1;
          step();
          rst = 1'b0;
          chk("rst_ready", in_ready, 1);
          chk("rst_m", {m3, m2, m1, m0}, 0);
          chk("rst_start", start, 0);
          chk("rst_tau1", tau1, 0);
          chk("rst_tau2", tau2, 0);
          chk("rst_tau3", tau3, 0);
          chk("rst_tvalid", tau_valid, 0);
          chk("rst_terr", timeout_err, 0);
          chk("rst_busy", busy, 0);
          return;
        end
        if (poke) begin
          in_valid = 1'b1;
          in_s0 = 16'hA5A5; in_s1 = 16'h5A5A; in_s2 = 16'hFFFF; in_s3 = 16'h1234;
        end
        step();
      end
      in_valid = 1'b0;
      chk("m_idle", {m3, m2, m1, m0}, 0);
      chk("ready_wait", in_ready, 0);
      chk("busy_wait", busy, 1);
    end
  endtask

  // Called in the first WAIT cycle: pulse cc_done with lags, expect taus.
  task automatic give_done(input int i1, input int i2, input int i3,
                           input int e1, input int e2, input int e3);
    bit seen = 1'b0;
    int lat  = 0;
    cc_done   = 1'b1;
    cc_index1 = 16'(i1);
    cc_index2 = 16'(i2);
    cc_index3 = 16'(i3);
    step();
    cc_done = 1'b0;
    lat = 1;
    while (!seen && lat <= 4) begin
      if (tau_valid === 1'b1) seen = 1'b1;
      else begin
        step();
        lat++;
      end
    end
    chk("tau_valid_seen", seen, 1);
    if (seen) begin
      chk("tau1", tau1, e1);
      chk("tau2", tau2, e2);
      chk("tau3", tau3, e3);
      step();
      chk("tau_valid_pulse", tau_valid, 0);
      chk("ready_after_out", in_ready, 1);
      chk("tau1_held", tau1, e1);
      chk("tau2_held", tau2, e2);
    end
  endtask

  initial begin
    int n;
    bit tv_seen;
    rst = 1'b1; in_valid = 1'b0; cc_done = 1'b0;
    in_s0 = '0; in_s1 = '0; in_s2 = '0; in_s3 = '0;
    cc_index1 = '0; cc_index2 = '0; cc_index3 = '0;
    step(); step();
    chk("reset_ready", in_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_start", start, 0);
    chk("reset_m", {m3, m2, m1, m0}, 0);
    chk("reset_tvalid", tau_valid, 0);
    chk("reset_terr", timeout_err, 0);
    chk("reset_tau1", tau1, 0);
    rst = 1'b0;
    step();

    // Frame 1: plain ramp, lags (19,-7,0)
    fill_frame(0, 1'b0);
    stream_check(-1, 1'b0);
    give_done(19, -7, 0, 12, -4, 0);

    // Frame 2: gapped fill, cc_done held from before START, junk in_valid
    // during the stream; extreme lags
    cc_done = 1'b1;
    cc_index1 = 16'h1FFF; cc_index2 = 16'hE000; cc_index3 = '0;
    fill_frame(100, 1'b1);
    stream_check(-1, 1'b1);
    give_done(8191, -8192, 0, 5591, -5592, 0);

    // Frame 3: no cc_done, junk in_valid during stream and wait -> timeout
    fill_frame(200, 1'b0);
    stream_check(-1, 1'b1);
    in_valid = 1'b1;
    in_s0 = 16'hDEAD; in_s1 = 16'hDEAD; in_s2 = 16'hDEAD; in_s3 = 16'hDEAD;
    n = 0;
    tv_seen = 1'b0;
    while (in_ready !== 1'b1 && n < int'(TO) + 20) begin
      if (tau_valid === 1'b1) tv_seen = 1'b1;
      step();
      n++;
    end
    in_valid = 1'b0;
    chk("timeout_cycles", n, TO);
    chk("timeout_err", timeout_err, 1);
    chk("timeout_no_tvalid", tv_seen, 0);
    chk("timeout_tau1_held", tau1, 5591);
    chk("timeout_busy", busy, 0);
    step(); step();
    chk("terr_sticky", timeout_err, 1);

    // Frame 4: start clears timeout_err; reset mid-stream
    terr_at_1 = 1'b1;
    fill_frame(300, 1'b0);
    stream_check(20, 1'b0);
    chk("terr_cleared_by_start", terr_at_1, 0);
    step();

    // Frame 5: full frame from sample 0 after the abandoned one
    fill_frame(400, 1'b0);
    stream_check(-1, 1'b0);
    give_done(100, -100, 1, 68, -68, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/cc_sample_streamer.md
CC_SAMPLE_STREAMER -- requirements
Module: cc_sample_streamer

Interface
REQ-001 SHALL have parameter LENGTH, default 8192, samples per correlation frame.
REQ-002 SHALL have parameter ADDR_W, default 13, frame address width (2^ADDR_W >= LENGTH).
REQ-003 SHALL have parameter TAU_MUL, default 44739, lag-to-tau multiplier (round(2^25 * 2^16 / 49152000)).
REQ-004 SHALL have parameter TAU_SHIFT, default 16, right shift applied after TAU_MUL.
REQ-005 SHALL have parameter TIMEOUT, default 65536, maximum cycles spent waiting for cc_done.
REQ-006 SHALL have ports: clk in 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have ports: rst in 1, reset, synchronous and active-high.
REQ-008 SHALL have ports: in_valid in 1 and in_ready out 1, the capture handshake.
REQ-009 SHALL have ports: in_s0, in_s1, in_s2, in_s3 in 16, the four mic samples of one capture beat.
REQ-010 SHALL have ports: start out 1, a one-cycle correlation start to the three cc_1 instances.
REQ-011 SHALL have ports: m0, m1, m2, m3 out 16, streamed samples; m0 is the reference channel for all correlators.
REQ-012 SHALL have ports: cc_done in 1, the correlators' done; cc_index1, cc_index2, cc_index3 in 16, signed lags.
REQ-013 SHALL have ports: tau1, tau2, tau3 out 32 signed, scaled delays for localizer_2; tau_valid out 1, a one-cycle pulse.
REQ-014 SHALL have ports: busy out 1 (state != FILL) and timeout_err out 1 (sticky until the next start).

Function
REQ-015 SHALL implement states FILL, START, STREAM, WAIT, SCALE, OUT.
REQ-016 FILL: in_ready=1; each cycle with in_valid=1 SHALL write in_s0..3 to wr_addr and increment wr_addr.
REQ-017 A write at wr_addr=LENGTH-1 SHALL move the block to START with wr_addr back at 0.
REQ-018 in_ready SHALL be 0 in every state except FILL; in_valid outside FILL SHALL be ignored, with no write.
REQ-019 START lasts exactly one cycle: start=1, with sample 0 of all channels on m0..m3 in the same cycle.
REQ-020 STREAM SHALL present sample k on m0..m3 in cycle k after START, for k=1..LENGTH-1, one per cycle with no gaps.
REQ-021 Outputs m0..m3 SHALL be registered; read addresses are prefetched so synchronous-read RAM meets REQ-019/020.
REQ-022 After sample LENGTH-1 the block SHALL enter WAIT; m0..m3 SHALL be held at 0 outside START/STREAM.
REQ-023 cc_done SHALL be ignored in START and STREAM, since a stale done from a previous frame must not end the wait.
REQ-024 WAIT: cc_done=1 SHALL latch cc_index1..3 and go to SCALE.
REQ-025 WAIT: after TIMEOUT cycles without cc_done, the block SHALL set timeout_err and return to FILL without tau_valid.
REQ-026 SCALE: tau_n = signed(cc_index_n) * TAU_MUL, a 33-bit signed product.
REQ-027 SCALE: the product SHALL be divided by 2^TAU_SHIFT with truncation toward zero, not an arithmetic-shift floor, then sign-extended to 32 bits.
REQ-028 SCALE may take 1-3 cycles (pipelined or one multiplier time-shared); the fixed total WAIT-exit-to-tau_valid latency SHALL be at most 4 cycles.
REQ-029 OUT: tau_valid=1 for one cycle; tau1..3 SHALL hold their values until the next OUT or reset; next state FILL.
REQ-030 start SHALL clear timeout_err.

Reset
REQ-031 rst=1 SHALL force FILL in any state, including mid-STREAM or mid-WAIT, and abandon the current frame.
REQ-032 Reset SHALL clear wr_addr, rd_addr, start, m0..m3, tau1..3, tau_valid, timeout_err and the timeout counter, and set in_ready=1 in the first cycle after rst.
REQ-033 Frame RAM contents need not be cleared.

Structure
REQ-034 A shared package cc_pkg SHALL hold LENGTH, ADDR_W, TAU_MUL, TAU_SHIFT, the state encoding, and the constants s=33554432 and fs=49152000.
REQ-035 The frame memory SHALL be one sub-module cc_frame_ram: 4x16-bit wide, LENGTH deep, one write port and one synchronous read port.
REQ-036 All else (FSM, counters, scaler) SHALL live in cc_sample_streamer.

Verification
REQ-037 Ramp fill: s0=k, s1=k+1, s2=k+2, s3=k+3 for k=0..8191, in_valid always high -> start one cycle, then m0=0..8191 on consecutive cycles with start at m0=0, and in_ready=0 throughout.
REQ-038 in_valid toggled 1/0 during fill -> only 8192 accepted beats are streamed, in order, with none dropped or duplicated.
REQ-039 Scaling: cc_index=(19,-7,0) with cc_done -> tau=(12,-4,0) and a single tau_valid pulse; cc_index=8191 -> 5591; cc_index=-8192 -> -5592.
REQ-040 cc_done held high from before START -> no exit from WAIT until after STREAM; with cc_done never asserted -> timeout_err=1 after 65536 WAIT cycles, no tau_valid, and in_ready=1.
REQ-041 rst asserted at stream sample 4000 -> next cycle FILL, in_ready=1, m0..m3=0, start=0, taus=0; the next full frame streams from sample 0.
REQ-042 in_valid=1 during STREAM/WAIT -> the RAM contents of the streamed frame are unchanged (compare m0..m3 to the ramp).
